// File: rtl/ntt_stage_ctrl_pkg.sv
// Shared types and defaults for the NTT stage sequencer.
package ntt_stage_ctrl_pkg;

  localparam int ADDR_W_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT,
    S_DRAIN,
    S_UNLOAD,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/ntt_stage_ctrl.sv
// NTT core sequencer: loads N coefficients, runs LOGN addrgen stages with a
// pipeline drain and bank-pair swap after each, then streams the result out.
module ntt_stage_ctrl
  import ntt_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LOGN     = ADDR_W + 1,
  parameter int PIPE_LAT = 4,
  localparam int STAGE_W = $clog2(LOGN) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               load_we,
  output logic               load_bank,
  output logic [ADDR_W-1:0]  load_addr,
  output logic               ag_start,
  output logic               ag_valid,
  input  logic               stage_done,
  output logic [STAGE_W-1:0] stage,
  output logic               rd_pair,
  input  logic               out_ready,
  output logic               unload_re,
  output logic               unload_bank,
  output logic [ADDR_W-1:0]  unload_addr,
  output logic               out_valid,
  output logic               out_last
);

  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [ADDR_W:0]    CNT_LAST   = '1;
  localparam logic [ADDR_W:0]    CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_LAT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [STAGE_W-1:0] STAGE_ONE  = STAGE_W'(1);
  localparam logic [STAGE_W-1:0] STAGE_END  = STAGE_W'(LOGN);

  state_t               state;
  logic [ADDR_W:0]      load_cnt;
  logic [ADDR_W:0]      unload_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [STAGE_W-1:0]   stage_nxt;

  // Counter bit 0 interleaves words across the two banks of a pair.
  assign load_we     = in_valid & in_ready;
  assign load_bank   = load_cnt[0];
  assign load_addr   = load_cnt[ADDR_W:1];
  assign unload_re   = out_ready & (state == S_UNLOAD);
  assign unload_bank = unload_cnt[0];
  assign unload_addr = unload_cnt[ADDR_W:1];
  assign stage_nxt   = stage + STAGE_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b0;
      ag_start   <= 1'b0;
      ag_valid   <= 1'b0;
      stage      <= '0;
      rd_pair    <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      load_cnt   <= '0;
      unload_cnt <= '0;
      drain_cnt  <= '0;
    end else begin
      out_valid <= unload_re;
      case (state)
        S_IDLE: begin
          if (go) begin
            state    <= S_LOAD;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            load_cnt <= '0;
            rd_pair  <= 1'b0;
            stage    <= '0;
          end
        end
        S_LOAD: begin
          if (load_we) begin
            if (load_cnt == CNT_LAST) begin
              in_ready <= 1'b0;
              ag_start <= 1'b1;
              state    <= S_RUN;
            end else begin
              load_cnt <= load_cnt + CNT_ONE;
            end
          end
        end
        S_RUN: begin
          ag_start <= 1'b0;
          ag_valid <= 1'b1;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (stage_done) begin
            ag_valid  <= 1'b0;
            drain_cnt <= DRAIN_INIT;
            state     <= S_DRAIN;
          end
        end
        // Last drain cycle: results of this stage are now in the other pair.
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            rd_pair <= ~rd_pair;
            stage   <= stage_nxt;
            if (stage_nxt == STAGE_END) begin
              unload_cnt <= '0;
              state      <= S_UNLOAD;
            end else begin
              ag_start <= 1'b1;
              state    <= S_RUN;
            end
          end else begin
            drain_cnt <= drain_cnt - DRAIN_ONE;
          end
        end
        S_UNLOAD: begin
          if (unload_re) begin
            if (unload_cnt == CNT_LAST) begin
              out_last <= 1'b1;
              done     <= 1'b1;
              state    <= S_FLUSH;
            end else begin
              unload_cnt <= unload_cnt + CNT_ONE;
            end
          end
        end
        S_FLUSH: begin
          out_last <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: two instances (LOGN=4 and LOGN=3), randomized
// handshakes, and a per-instance monitor scored against arithmetic expectations.
module tb_ntt_stage_ctrl;

  localparam int AW     = 3;
  localparam int N      = 16;
  localparam int PL     = 2;
  localparam int SD_DLY = 8;

  typedef struct packed {
    int ld_idx;
    int ld_err;
    int n_ag;
    int gap_err;
    int last_sd;
    int n_ur;
    int ur_err;
    int n_ov;
    int ov_err;
    int last_err;
    int n_done;
  } stats_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic go [2], in_valid [2], out_ready [2], sd_man [2], sd_en [2], clr [2];
  logic stage_done [2];
  logic busy [2], done [2], in_ready [2], load_we [2], load_bank [2];
  logic ag_start [2], ag_valid [2], rd_pair [2], unload_re [2], unload_bank [2];
  logic out_valid [2], out_last [2];
  logic [AW-1:0] load_addr [2], unload_addr [2];
  logic [2:0] stage [2];
  stats_t stats [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LG = (g == 0) ? 4 : 3;
    stats_t st;
    logic sd_auto;
    logic prev_re;
    int sd_tmr;

    assign stage_done[g] = sd_auto | sd_man[g];
    assign stats[g] = st;

    ntt_stage_ctrl #(.ADDR_W(AW), .LOGN(LG), .PIPE_LAT(PL)) u_dut (
      .clk(clk), .reset(reset), .go(go[g]), .busy(busy[g]), .done(done[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .load_we(load_we[g]),
      .load_bank(load_bank[g]), .load_addr(load_addr[g]),
      .ag_start(ag_start[g]), .ag_valid(ag_valid[g]),
      .stage_done(stage_done[g]), .stage(stage[g]), .rd_pair(rd_pair[g]),
      .out_ready(out_ready[g]), .unload_re(unload_re[g]),
      .unload_bank(unload_bank[g]), .unload_addr(unload_addr[g]),
      .out_valid(out_valid[g]), .out_last(out_last[g])
    );

    // Observes cycle k at negedge k; stage_done set here is seen at the next posedge.
    always @(negedge clk) begin
      if (clr[g]) begin
        st         <= '0;
        st.last_sd <= -1000;
        sd_auto    <= 1'b0;
        sd_tmr     <= 0;
        prev_re    <= 1'b0;
      end else begin
        prev_re <= unload_re[g];
        sd_auto <= 1'b0;
        if (load_we[g]) begin
          st.ld_idx <= st.ld_idx + 1;
          if (st.ld_idx >= N || int'(load_bank[g]) != st.ld_idx % 2 ||
              int'(load_addr[g]) != st.ld_idx / 2)
            st.ld_err <= st.ld_err + 1;
        end
        if (ag_start[g]) begin
          st.n_ag <= st.n_ag + 1;
          if (cyc - st.last_sd < PL + 1) st.gap_err <= st.gap_err + 1;
          sd_tmr <= SD_DLY;
        end else if (sd_tmr > 0) begin
          sd_tmr <= sd_tmr - 1;
          if (sd_tmr == 1 && sd_en[g]) begin
            sd_auto <= 1'b1;
            if (ag_valid[g]) st.last_sd <= cyc;
          end
        end
        if (unload_re[g]) begin
          st.n_ur <= st.n_ur + 1;
          if (st.n_ur >= N || int'(unload_bank[g]) != st.n_ur % 2 ||
              int'(unload_addr[g]) != st.n_ur / 2 || int'(rd_pair[g]) != LG % 2)
            st.ur_err <= st.ur_err + 1;
        end
        if (out_valid[g] != prev_re) st.ov_err <= st.ov_err + 1;
        if (out_valid[g]) st.n_ov <= st.n_ov + 1;
        if ((out_last[g] != (out_valid[g] && st.n_ov == N - 1)) || (done[g] != out_last[g]))
          st.last_err <= st.last_err + 1;
        if (done[g]) st.n_done <= st.n_done + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int d);
    clr[d] = 1'b1;
    tick();
    clr[d] = 1'b0;
    go[d] = 1'b1;
    tick();
    go[d] = 1'b0;
  endtask

  // mode 0: in_valid held high; 1: toggled 1010...; 2: high plus a stray stage_done
  task automatic do_load(input int d, input int mode);
    bit left = 1'b0;
    for (int i = 0; i < 200 && !left; i++) begin
      in_valid[d] = (mode == 1) ? ((i % 2) == 0) : 1'b1;
      sd_man[d] = (mode == 2 && i == 5);
      tick();
      if (!in_ready[d]) left = 1'b1;
    end
    in_valid[d] = 1'b0;
    sd_man[d] = 1'b0;
    if (!left) check("load_timeout", 0, 1);
  endtask

  task automatic wait_done(input int d, input bit rnd);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      out_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (done[d]) seen = 1'b1;
    end
    out_ready[d] = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    tick();
    tick();
  endtask

  task automatic final_checks(input int d, input int logn);
    check("loads", stats[d].ld_idx, N);
    check("load_seq", stats[d].ld_err, 0);
    check("ag_starts", stats[d].n_ag, logn);
    check("ag_gap", stats[d].gap_err, 0);
    check("reads", stats[d].n_ur, N);
    check("read_seq", stats[d].ur_err, 0);
    check("out_valid_cnt", stats[d].n_ov, N);
    check("out_valid_lag", stats[d].ov_err, 0);
    check("last_done_align", stats[d].last_err, 0);
    check("done_cnt", stats[d].n_done, 1);
    check("rd_pair_end", rd_pair[d], logn % 2);
    check("stage_end", stage[d], logn);
    check("busy_end", busy[d], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int falls;
    bit prev_av, found;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      go[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      sd_man[d] = 1'b0; sd_en[d] = 1'b1; clr[d] = 1'b1;
    end
    tick();
    tick();

    // Reset held with active-looking inputs: everything stays quiet.
    for (int d = 0; d < 2; d++) begin
      go[d] = 1'b1; in_valid[d] = 1'b1; out_ready[d] = 1'b1; sd_man[d] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        check("rst_busy", busy[d], 0);
        check("rst_in_ready", in_ready[d], 0);
        check("rst_ag_start", ag_start[d], 0);
        check("rst_out_valid", out_valid[d], 0);
        check("rst_done", done[d], 0);
        check("rst_rd_pair", rd_pair[d], 0);
        check("rst_stage", stage[d], 0);
      end
    end
    for (int d = 0; d < 2; d++) begin
      go[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0; sd_man[d] = 1'b0;
    end
    reset = 1'b1;
    tick();
    clr[0] = 1'b0;
    clr[1] = 1'b0;

    // Full run, LOGN=4, continuous load and unload.
    start_run(0);
    check("busy_after_go", busy[0], 1);
    do_load(0, 0);
    wait_done(0, 1'b0);
    final_checks(0, 4);

    // Full run, LOGN=3: odd stage count leaves rd_pair at 1.
    start_run(1);
    do_load(1, 0);
    wait_done(1, 1'b0);
    final_checks(1, 3);

    // Gappy load and random out_ready.
    start_run(0);
    do_load(0, 1);
    wait_done(0, 1'b1);
    final_checks(0, 4);

    // Stray stage_done in LOAD, go in WAIT, then reset during DRAIN.
    start_run(0);
    do_load(0, 2);
    check("ld_after_stray_sd", stats[0].ld_idx, N);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (ag_valid[0]) found = 1'b1;
    end
    if (!found) check("wait_timeout", 0, 1);
    go[0] = 1'b1;
    tick();
    go[0] = 1'b0;
    check("go_in_wait_in_ready", in_ready[0], 0);
    check("go_in_wait_ag_valid", ag_valid[0], 1);
    check("go_in_wait_stage", stage[0], 0);
    falls = 0;
    prev_av = ag_valid[0];
    for (int i = 0; i < 100 && falls < 2; i++) begin
      tick();
      if (prev_av && !ag_valid[0]) falls++;
      prev_av = ag_valid[0];
    end
    check("drain_reached", falls, 2);
    check("pre_reset_rd_pair", rd_pair[0], 1);
    check("pre_reset_stage", stage[0], 1);
    reset = 1'b0;
    #2;
    check("abort_busy", busy[0], 0);
    check("abort_rd_pair", rd_pair[0], 0);
    check("abort_stage", stage[0], 0);
    check("abort_ag_valid", ag_valid[0], 0);
    check("abort_done", done[0], 0);
    tick();
    reset = 1'b1;
    tick();

    start_run(0);
    do_load(0, 0);
    wait_done(0, 1'b1);
    final_checks(0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
